// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, read-modify-write for sub-word stores.
// Optional build macro MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module load_store_unit #(
  parameter int unsigned RAM_LATENCY = 1,
  parameter bit          WORD_ADDR   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;

  localparam logic [1:0] LAT_LAST = 2'(RAM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        write_q;
  logic        err_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        misalign;
  logic        req_err;
  logic [1:0]  req_off;
  logic        rd_done;
  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] ext;
  logic [31:0] mask;
  logic [31:0] repl;
  logic [31:0] merged;

  assign accept = req_valid && (state_q == IDLE);

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = (req_size == 2'b11) || misalign;
  // Low address bits below the access size are dropped so lanes stay naturally aligned.
  assign req_off = (req_size == 2'b10) ? 2'b00 :
                   (req_size == 2'b01) ? {req_addr[1], 1'b0} : req_addr[1:0];
  assign rd_done = (state_q == RD_WAIT) && (cnt_q == LAT_LAST);

  assign sh   = {off_q, 3'b000};
  assign lane = mem_rdata >> sh;

  always_comb begin
    ext = lane;
    case (size_q)
      2'b00:   ext = uns_q ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   ext = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ext = lane;
    endcase
  end

  assign mask   = (size_q == 2'b00) ? (32'h0000_00FF << sh) : (32'h0000_FFFF << sh);
  assign repl   = (size_q == 2'b00) ? {4{wdata_q[7:0]}} : {2{wdata_q[15:0]}};
  assign merged = (mem_rdata & ~mask) | (repl & mask);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                                state_d = RESP;
          else if (req_write && (req_size == 2'b10)) state_d = WRITE;
          else                                        state_d = RD_WAIT;
        end
      end
      RD_WAIT: if (rd_done) state_d = write_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      off_q     <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q   <= '0;
            off_q   <= req_off;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            write_q <= req_write;
            err_q   <= req_err;
            wdata_q <= req_wdata;
            if (req_err) begin
              rsp_rdata <= '0;
            end else begin
              mem_addr <= WORD_ADDR ? {2'b00, req_addr[31:2]} : {req_addr[31:2], 2'b00};
              if (req_write && (req_size == 2'b10)) mem_wdata <= req_wdata;
            end
          end
        end
        RD_WAIT: begin
          if (!rd_done)     cnt_q     <= cnt_q + 2'd1;
          else if (write_q) mem_wdata <= merged;
          else              rsp_rdata <= ext;
        end
        WRITE:   rsp_rdata <= '0;
        default: ;
      endcase
    end
  end

  assign mem_we    = (state_q == WRITE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = (state_q == RESP) && err_q;
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a combinational-read word RAM (RAM_LATENCY=1, WORD_ADDR=1).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [0:63];

  always #5 clk = ~clk;

  load_store_unit #(.RAM_LATENCY(1), .WORD_ADDR(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .busy         (busy)
  );

  // Latency-1 RAM as the unit sees it: data for the registered address is valid in the same cycle.
  assign mem_rdata = ram[mem_addr[5:0]];
  always @(posedge clk) if (mem_we) ram[mem_addr[5:0]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request for one cycle; returns just after the accept edge (start of cycle 1).
  task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = d;
    chk("req_ready_at_issue", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] exp);
    issue(1'b0, sz, uns, a, 32'h0);
    @(negedge clk);
    chk({tag, "_c1_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
    chk({tag, "_c1_mem_we"}, {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    chk({tag, "_c2_rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
    chk({tag, "_rdata"}, rsp_rdata, exp);
    chk({tag, "_err"}, {31'h0, rsp_err}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;

    // 1. Word store then word load
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("ws_c1_mem_we", {31'h0, mem_we}, 32'h1);
    chk("ws_c1_mem_addr", mem_addr, 32'h4);
    chk("ws_c1_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("ws_c1_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("ws_c1_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("ws_c2_mem_we", {31'h0, mem_we}, 32'h0);
    chk("ws_c2_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("ws_c2_rsp_err", {31'h0, rsp_err}, 32'h0);
    do_load("wl", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("wl_c3_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("wl_c3_rdata_hold", rsp_rdata, 32'hDEADBEEF);

    // 2. Byte store read-modify-write
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000005A);
    @(negedge clk);
    chk("bs_c1_mem_we", {31'h0, mem_we}, 32'h0);
    chk("bs_c1_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("bs_c2_mem_we", {31'h0, mem_we}, 32'h1);
    chk("bs_c2_mem_addr", mem_addr, 32'h4);
    chk("bs_c2_mem_wdata", mem_wdata, 32'hDEAD5AEF);
    chk("bs_c2_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    chk("bs_c3_mem_we", {31'h0, mem_we}, 32'h0);
    chk("bs_c3_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("bs_c3_rdata_zero", rsp_rdata, 32'h0);
    chk("bs_ram_word", ram[4], 32'hDEAD5AEF);

    // 3. Sub-word loads with extension
    do_load("lb_s13", 2'b00, 1'b0, 32'h13, 32'hFFFFFFDE);
    do_load("lb_u13", 2'b00, 1'b1, 32'h13, 32'h000000DE);
    do_load("lh_s12", 2'b01, 1'b0, 32'h12, 32'hFFFFDEAD);
    do_load("lb_s11", 2'b00, 1'b0, 32'h11, 32'h0000005A);
    do_load("lh_u10", 2'b01, 1'b1, 32'h10, 32'h00005AEF);

    // 4. Misaligned word load
`ifdef MISALIGN_TRAP_EN
    issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    @(negedge clk);
    chk("mis_c1_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("mis_c1_rsp_err", {31'h0, rsp_err}, 32'h1);
    chk("mis_c1_rdata", rsp_rdata, 32'h0);
    chk("mis_c1_mem_we", {31'h0, mem_we}, 32'h0);
`else
    do_load("mis_wl", 2'b10, 1'b0, 32'h12, 32'hDEAD5AEF);
`endif

    // Half store into an empty word
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF);
    @(negedge clk);
    chk("hs_c1_mem_we", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    chk("hs_c2_mem_we", {31'h0, mem_we}, 32'h1);
    chk("hs_c2_mem_addr", mem_addr, 32'h8);
    chk("hs_c2_mem_wdata", mem_wdata, 32'hBEEF0000);
    @(negedge clk);
    chk("hs_c3_rsp_valid", {31'h0, rsp_valid}, 32'h1);

    // 5. Reset during the WRITE cycle of a byte store
    issue(1'b1, 2'b00, 1'b0, 32'h24, 32'h00000077);
    @(negedge clk);
    @(negedge clk);
    chk("rw_c2_mem_we", {31'h0, mem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rw_mem_we_drop", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    chk("rw_rsp_valid_a", {31'h0, rsp_valid}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rw_rsp_valid_b", {31'h0, rsp_valid}, 32'h0);
    chk("rw_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rw_busy", {31'h0, busy}, 32'h0);
    chk("rw_ram_untouched", ram[9], 32'h0);

    // 6. Illegal size, then back-to-back load
    do_load("pre_ill", 2'b10, 1'b0, 32'h10, 32'hDEAD5AEF);
    issue(1'b1, 2'b11, 1'b0, 32'h20, 32'h00001234);
    @(negedge clk);
    chk("ill_c1_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("ill_c1_rsp_err", {31'h0, rsp_err}, 32'h1);
    chk("ill_c1_rdata", rsp_rdata, 32'h0);
    chk("ill_c1_mem_we", {31'h0, mem_we}, 32'h0);
    chk("ill_ram_word", ram[8], 32'hBEEF0000);
    do_load("b2b", 2'b10, 1'b0, 32'h10, 32'hDEAD5AEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the data-memory interface. It accepts one load or store request at a time from the datapath and drives the synchronous single-port data RAM. Sub-word stores use read-modify-write, because the RAM write enable covers the whole word. Loads return sign- or zero-extended byte, half or word data with a response handshake.

Parameters:
RAM_LATENCY, 1, cycles from mem_addr valid to mem_rdata valid (legal range 1-3)
WORD_ADDR, 1, 1: mem_addr = word index {2'b00, addr[31:2]}; 0: mem_addr = {addr[31:2], 2'b00}

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept (high only in IDLE)
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  load result (0 for stores and errors)
rsp_err  out  1  response carries an error
mem_we  out  1  RAM write enable
mem_addr  out  32  RAM address
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values: state IDLE, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Asserting rst_n mid-operation clears mem_we immediately and aborts the transaction. No response is ever issued for the aborted transaction.
- Accept: req_valid && req_ready at a rising edge. Address, size, data and flags are latched at that edge; mem_addr is registered at the same edge.
- States: IDLE, RD_WAIT, WRITE, RESP.
- IDLE transitions on accept:
  - load -> RD_WAIT
  - word store -> WRITE
  - byte/half store -> RD_WAIT
  - error -> RESP
- RD_WAIT: counts RAM_LATENCY cycles, then captures mem_rdata.
  - Load: extract the addressed lane, extend it, load rsp_rdata, go to RESP.
  - Sub-word store: merge the new lane(s) into the captured word, put the result on mem_wdata, go to WRITE.
- WRITE: mem_we=1 for exactly one cycle with stable mem_addr/mem_wdata, then RESP.
- RESP: rsp_valid=1 for one cycle, then IDLE. A new request can be accepted in the next cycle.
- Latency, with the accept cycle numbered 0:
  - load: rsp_valid in cycle RAM_LATENCY+1
  - word store: mem_we in cycle 1, rsp_valid in cycle 2
  - sub-word store: mem_we in cycle RAM_LATENCY+1, rsp_valid in cycle RAM_LATENCY+2
  - error: rsp_valid in cycle 1
- Lanes are little-endian: byte k is bits [8k+7:8k] with k = addr[1:0]; half-word select is addr[1].
- Sign extension copies the lane MSB into the upper bits. req_unsigned forces zeros into the upper bits.
- Outputs outside their active phases:
  - mem_we is 0 outside WRITE.
  - rsp_err is valid only with rsp_valid.
  - rsp_rdata holds its last value until the next response.
- req_size=11 always gives rsp_err=1 with no RAM access (mem_we stays 0).
- req_valid seen while busy is ignored. The requester must hold the request until it is accepted.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a half-word access with addr[0]=1, or a word access with addr[1:0]!=00, gets no RAM access and goes straight to RESP with rsp_err=1, rsp_rdata=0.
- Not defined: misaligned low address bits are ignored. Word accesses use addr[1:0]=00; half-word accesses use addr[0]=0. rsp_err is raised only for req_size=11.

Test Plan:
All scenarios use RAM_LATENCY=1, WORD_ADDR=1.
1. Word store 0xDEADBEEF to 0x10, then word load 0x10 -> mem_we high in cycle 1 only with mem_addr=0x4 and mem_wdata=0xDEADBEEF; the load returns rsp_rdata=0xDEADBEEF with rsp_valid in cycle 2, rsp_err=0.
2. Byte store 0x5A to 0x11 over word 0xDEADBEEF -> read phase first, then mem_we in cycle 2 with mem_wdata=0xDEAD5AEF; rsp_valid in cycle 3.
3. Loads from the word 0xDEAD5AEF, expected rsp_rdata:
   - signed byte at 0x13 -> 0xFFFFFFDE
   - unsigned byte at 0x13 -> 0x000000DE
   - signed half at 0x12 -> 0xFFFFDEAD
   - signed byte at 0x11 -> 0x0000005A
4. Word load at 0x12:
   - with MISALIGN_TRAP_EN: rsp_err=1, rsp_rdata=0, rsp_valid in cycle 1, mem_we never asserted
   - without it: returns the word at 0x10
5. rst_n pulled low during the WRITE cycle of a sub-word store -> mem_we drops within the same cycle and rsp_valid is never asserted; after release req_ready=1 and busy=0.
6. req_size=11 store to 0x20 -> rsp_err=1 in cycle 1, mem_we stays 0. A back-to-back word load issued in the cycle after RESP is accepted immediately.
